sar_mem_writer: RTL
===================

// Module: sar_mem_writer
// PURPOSE
//  Write-side counterpart of the 16x4 SAR lookup ROM path: loads a burst of data words into a 16-entry memory.
//  Burst starts at a given base address and auto-increments, with wrap at the top entry.
//  Accepts words over a valid/ready stream. Issues one registered write strobe per accepted word.
//  Sits between the table-load source and the memory that the SAR read port fetches from.
// PARAMETERS
//  DW     4   data word width
//  AW     4   address width
//  DEPTH  16  entries; always 2**AW
// PORTS
//  clk        in   1     sole clock, rising edge
//  rst        in   1     synchronous, active-low reset (sampled on clk rising edge; 0 = reset)
//  start      in   1     begin burst; sampled only in IDLE
//  base_addr  in   AW    first write address, latched on start
//  len        in   AW+1  burst length 0..DEPTH, latched on start
//  din        in   DW    stream data
//  din_valid  in   1     stream data valid
//  din_ready  out  1     block accepts din this cycle
//  wr_en      out  1     memory write strobe, 1-cycle pulse per word
//  wr_addr    out  AW    memory write address
//  wr_data    out  DW    memory write data
//  busy       out  1     high whenever state != IDLE
//  done       out  1     1-cycle pulse at end of burst
//  count      out  AW+1  words accepted in the current/last burst
// BEHAVIOUR
//  - Reset (rst==0 at edge): state=IDLE; wr_en=0; wr_addr=0; wr_data=0; done=0; count=0; ptr=0.
//    busy=0 and din_ready=0 follow from IDLE.
//  - Reset mid-burst aborts immediately. No wr_en after the reset edge, and no done pulse.
//  - FSM IDLE -> WRITE -> DONE -> IDLE.
//    din_ready = (state==WRITE), combinational from state. busy = (state!=IDLE).
//  - IDLE, start=1, len!=0: latch ptr=base_addr and len; clear count; next state WRITE.
//  - IDLE, start=1, len==0: clear count; next state DONE. No writes.
//  - WRITE, din_valid&din_ready (accept) at edge:
//    wr_en=1, wr_addr=ptr, wr_data=din (latency 1 cycle); ptr=ptr+1 mod DEPTH; count=count+1.
//  - WRITE, no accept at edge: wr_en=0; ptr and count hold.
//  - Accept that makes count==len: next state DONE, so din_ready drops the following cycle.
//  - DONE: done=1 for exactly 1 cycle; next state IDLE. wr_en of the last word coincides with done.
//  - start ignored in WRITE and DONE.
//  - count holds after the burst until the next start.
//  - Wrap-around: ptr 15 -> 0. len==DEPTH rewrites every entry exactly once.
// CONFIGURATION
//  - SAR_MEM_WRITER_READBACK_EN defined:
//    - Block contains a DEPTH x DW shadow memory, written with every wr_en/wr_addr/wr_data.
//    - Extra ports: rd_en in 1, rd_addr in AW, rd_data out DW.
//    - rd_data <= mem[rd_addr] on the edge where rd_en=1; otherwise rd_data holds. Latency 1.
//    - rd_data resets to 0. Shadow contents are not cleared by reset.
//    - Read and write to the same address in the same cycle returns the old data.
//  - SAR_MEM_WRITER_READBACK_EN undefined: no shadow memory and no rd_* ports.
//    The block drives the write interface only.
// STRUCTURE
//  - Shared package sar_pkg:
//    - FSM state encoding IDLE=2'd0, WRITE=2'd1, DONE=2'd2.
//    - Default DW/AW/DEPTH constants.
//  - One sub-module, sar_shadow_ram (DEPTH x DW, 1 write port, 1 registered read port).
//    Instantiated only under SAR_MEM_WRITER_READBACK_EN.
// TESTING
//  1 Reset: rst=0 for 2 cycles mid-WRITE -> next cycle wr_en=0, busy=0, done=0, count=0, din_ready=0.
//  2 Basic burst: start, base=3, len=4; din 9,A,B,C continuous valid ->
//    wr_addr 3,4,5,6 with data 9,A,B,C on consecutive cycles; done with last wr_en; count=4.
//  3 Wrap: base=14, len=4 -> wr_addr 14,15,0,1; busy low 1 cycle after done.
//  4 Backpressure: din_valid toggled 1,0,1,0 -> wr_en only on cycles after valid beats.
//    ptr/count hold in gaps; start pulsed during WRITE is ignored.
//  5 len=0 -> done 1 cycle after start, zero wr_en, count=0. len=16, base=0 -> 16 writes, addr 0..15.
//  6 READBACK_EN: load 16 words mem[i]=~i; read addr 5 -> rd_data=4'b1010 one cycle later.
//    Same-cycle read/write to one address returns the old value.

Source files
------------

// File: rtl/sar_pkg.sv
// Shared constants and FSM encoding for the SAR table-load write path.
package sar_pkg;

  localparam int DW_DEF    = 4;
  localparam int AW_DEF    = 4;
  localparam int DEPTH_DEF = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sar_shadow_ram.sv
// DEPTH x DW shadow of the SAR lookup memory: one write port, one registered read port.
// Reading and writing one address on the same edge returns the pre-write contents.
module sar_shadow_ram
  import sar_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [DW-1:0] wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [DW-1:0] rdata
);

  logic [DW-1:0] mem [DEPTH];

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read; output holds while re is low.
  always_ff @(posedge clk) begin
    if (!rst)    rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/sar_mem_writer.sv
// Burst writer for the 16-entry SAR lookup memory.
// Accepts words over valid/ready and emits one registered write per word,
// starting at base_addr and wrapping from the top entry back to 0.
// Optional shadow memory with read port: SAR_MEM_WRITER_READBACK_EN.
//
//   state | meaning
//   IDLE  | waiting for start
//   WRITE | accepting stream words, din_ready high
//   DONE  | one-cycle end-of-burst, done pulse high
module sar_mem_writer
  import sar_pkg::*;
#(
  parameter int DW    = DW_DEF,
  parameter int AW    = AW_DEF,
  parameter int DEPTH = 2**AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic [AW-1:0] base_addr,
  input  logic [AW:0]   len,
  input  logic [DW-1:0] din,
  input  logic          din_valid,
  output logic          din_ready,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic [AW:0]   count
`ifdef SAR_MEM_WRITER_READBACK_EN
  ,
  input  logic          rd_en,
  input  logic [AW-1:0] rd_addr,
  output logic [DW-1:0] rd_data
`endif
);

  state_t        state, state_nx;
  logic [AW-1:0] ptr;
  logic [AW-1:0] ptr_nx;
  logic [AW:0]   len_q;
  logic [AW:0]   count_inc;
  logic          accept;

  assign din_ready = (state == WRITE);
  assign busy      = (state != IDLE);
  assign accept    = din_valid && din_ready;
  assign count_inc = count + 1'b1;
  assign ptr_nx    = (ptr == AW'(DEPTH - 1)) ? '0 : ptr + 1'b1;

  // State register; reset aborts any burst in flight.
  always_ff @(posedge clk) begin
    if (!rst) state <= IDLE;
    else      state <= state_nx;
  end

  // Next-state decode; start only matters in IDLE, a zero-length burst skips WRITE.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = (len == '0) ? DONE : WRITE;
      WRITE:   if (accept && (count_inc == len_q)) state_nx = DONE;
      DONE:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: burst setup, address pointer, word count and registered write strobe.
  always_ff @(posedge clk) begin
    if (!rst) begin
      ptr     <= '0;
      len_q   <= '0;
      count   <= '0;
      wr_en   <= 1'b0;
      wr_addr <= '0;
      wr_data <= '0;
      done    <= 1'b0;
    end else begin
      wr_en <= accept;
      done  <= (state_nx == DONE);
      if ((state == IDLE) && start) begin
        ptr   <= base_addr;
        len_q <= len;
        count <= '0;
      end
      if (accept) begin
        wr_addr <= ptr;
        wr_data <= din;
        ptr     <= ptr_nx;
        count   <= count_inc;
      end
    end
  end

`ifdef SAR_MEM_WRITER_READBACK_EN
  sar_shadow_ram #(
    .DW    (DW),
    .AW    (AW),
    .DEPTH (DEPTH)
  ) u_shadow (
    .clk   (clk),
    .rst   (rst),
    .we    (wr_en),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );
`endif

endmodule
